// File: rtl/upg_loader_ctrl.sv
// upg_loader_ctrl
// UART programming controller. Parses framed byte streams from the UART
// receiver (command, little-endian length, little-endian data words, XOR
// checksum) and turns them into one-cycle 32-bit word writes into either
// program_rom or dmemory32. The CPU is held in reset while a frame is being
// loaded.
//
// A frame is aborted in any of these cases:
//   - the command byte is unknown,
//   - the length is too large,
//   - the checksum is bad,
//   - the line goes idle for too long,
//   - start_pg is released mid-frame.
//
// Words already written before an abort are not rolled back.

module upg_loader_ctrl #(
  parameter int WORD_ADDR_W    = 14,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start_pg,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  output logic                   upg_wen_o,
  output logic [WORD_ADDR_W:0]   upg_adr_o,
  output logic [31:0]            upg_dat_o,
  output logic                   upg_done_o,
  output logic                   upg_err_o,
  output logic                   cpu_hold_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_LEN_L = 3'd2;
  localparam logic [2:0] S_LEN_H = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_CSUM  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_ERR   = 3'd7;

  // The timeout counter only ever has to reach TIMEOUT_CYCLES-1.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  // The largest legal word count fills one memory exactly.
  localparam logic [16:0] MAX_LEN = 17'(1) << WORD_ADDR_W;

  logic [2:0]             state;
  logic                   start_pg_d;
  logic                   target;
  logic [7:0]             len_l;
  logic [15:0]            len_m1;
  logic [7:0]             csum;
  logic [1:0]             byte_cnt;
  logic [WORD_ADDR_W-1:0] word_cnt;
  logic [31:0]            word_asm;
  logic [TW-1:0]          tcnt;

  logic                   start_evt;
  logic [7:0]             csum_next;
  logic [16:0]            len_full;
  logic [31:0]            word_next;
  logic                   last_word;

  assign start_evt  = start_pg & ~start_pg_d;
  assign csum_next  = csum ^ rx_data;
  assign len_full   = {1'b0, rx_data, len_l};
  assign word_next  = {rx_data, word_asm[31:8]};
  assign last_word  = (32'(word_cnt) == 32'(len_m1));
  assign cpu_hold_o = (state != S_IDLE);

  // Frame parser: start detection, byte decoding, word writes, checksum and
  // inactivity timeout. Byte handling in the frame states is gated first by
  // start_pg, so releasing it always aborts the frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      start_pg_d <= 1'b0;
      target     <= 1'b0;
      len_l      <= '0;
      len_m1     <= '0;
      csum       <= '0;
      byte_cnt   <= '0;
      word_cnt   <= '0;
      word_asm   <= '0;
      tcnt       <= '0;
      upg_wen_o  <= 1'b0;
      upg_adr_o  <= '0;
      upg_dat_o  <= '0;
      upg_done_o <= 1'b0;
      upg_err_o  <= 1'b0;
    end else begin
      start_pg_d <= start_pg;
      upg_wen_o  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_evt) begin
            upg_done_o <= 1'b0;
            upg_err_o  <= 1'b0;
            csum       <= '0;
            byte_cnt   <= '0;
            word_cnt   <= '0;
            tcnt       <= '0;
            state      <= S_CMD;
          end
        end
        S_DONE, S_ERR: begin
          if (!start_pg) state <= S_IDLE;
        end
        default: begin
          if (!start_pg) begin
            state     <= S_ERR;
            upg_err_o <= 1'b1;
          end else if (rx_valid) begin
            tcnt <= '0;
            csum <= csum_next;
            case (state)
              S_CMD: begin
                if (rx_data == 8'h00 || rx_data == 8'h01) begin
                  target <= rx_data[0];
                  state  <= S_LEN_L;
                end else begin
                  state     <= S_ERR;
                  upg_err_o <= 1'b1;
                end
              end
              S_LEN_L: begin
                len_l <= rx_data;
                state <= S_LEN_H;
              end
              S_LEN_H: begin
                if (len_full > MAX_LEN) begin
                  state     <= S_ERR;
                  upg_err_o <= 1'b1;
                end else if (len_full == 17'd0) begin
                  state <= S_CSUM;
                end else begin
                  len_m1 <= len_full[15:0] - 16'd1;
                  state  <= S_DATA;
                end
              end
              S_DATA: begin
                word_asm <= word_next;
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                  upg_wen_o <= 1'b1;
                  upg_dat_o <= word_next;
                  upg_adr_o <= {target, word_cnt};
                  word_cnt  <= word_cnt + WORD_ADDR_W'(1);
                  if (last_word) state <= S_CSUM;
                end
              end
              S_CSUM: begin
                if (csum_next == 8'h00) begin
                  state      <= S_DONE;
                  upg_done_o <= 1'b1;
                end else begin
                  state     <= S_ERR;
                  upg_err_o <= 1'b1;
                end
              end
              default: ;
            endcase
          end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state     <= S_ERR;
            upg_err_o <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: doc/upg_loader_ctrl.md
Name: upg_loader_ctrl

Overview:
- UART programming controller: turns the byte stream from the UART receiver into a sequence of 32-bit word writes to program_rom or dmemory32.
- Holds the CPU in reset while a download is in progress.
- Sits between the UART rx byte interface and the upg_* write ports of the instruction and data memories.
- Validates each frame with a command check, a length check, an XOR checksum and an inactivity timeout.

Parameters:
- WORD_ADDR_W, 14: word-address width per memory; maximum frame length is 2^WORD_ADDR_W words.
- TIMEOUT_CYCLES, 2000000: idle clock cycles allowed between bytes inside a frame before the frame is aborted.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start_pg  input  1  programming-mode request; level, already debounced and synchronised
- rx_valid  input  1  one-cycle strobe, one per received byte
- rx_data  input  8  received byte, valid when rx_valid=1
- upg_wen_o  output  1  one-cycle write strobe
- upg_adr_o  output  WORD_ADDR_W+1  bit[MSB] selects target (0=program_rom, 1=dmemory32); lower bits are the word address
- upg_dat_o  output  32  write data
- upg_done_o  output  1  frame completed with a good checksum
- upg_err_o  output  1  frame aborted
- cpu_hold_o  output  1  CPU reset request

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-high (reset).
- Reset values: state=IDLE; upg_wen_o=0, upg_adr_o=0, upg_dat_o=0, upg_done_o=0, upg_err_o=0, cpu_hold_o=0; start_pg_d=0; all counters=0.
- Reset mid-operation returns to IDLE immediately. Writes already issued stay in memory.
- Frame format, all bytes in order:
  - CMD: 0x00 = imem, 0x01 = dmem
  - LEN_L, LEN_H: word count N, little-endian
  - 4*N data bytes, each word little-endian (first byte goes to [7:0])
  - CSUM: XOR of every frame byte including CSUM must equal 0x00
- Start detection: start_pg is registered into start_pg_d. A start is start_pg=1 while start_pg_d=0. start_pg already high when reset releases therefore counts as a start.
- States:
  - IDLE: cpu_hold_o=0. On start: clear done, err, checksum, byte counter, word counter and timeout counter; go to CMD.
  - CMD: on byte, 0x00 or 0x01 latches the target bit and goes to LEN_L; any other value goes to ERR.
  - LEN_L: on byte, latch the low length byte; go to LEN_H.
  - LEN_H: on byte, go to ERR if N > 2^WORD_ADDR_W, to CSUM if N == 0, otherwise to DATA.
  - DATA: shift each byte into the word assembly register; byte counter counts 0..3. On the 4th byte:
    - next cycle: upg_wen_o=1 for exactly one cycle, upg_dat_o = assembled word, upg_adr_o = {target, word counter}
    - word counter then increments
    - after word N-1 is accepted, go to CSUM
  - CSUM: on byte, go to DONE if the running XOR including this byte is 0x00, otherwise to ERR.
  - DONE: upg_done_o=1; leave to IDLE when start_pg=0.
  - ERR: upg_err_o=1; leave to IDLE when start_pg=0.
- Flag lifetime: upg_done_o and upg_err_o stay set in IDLE until the next start.
- cpu_hold_o is 1 in every state other than IDLE.
- The checksum updates on every accepted byte from CMD through CSUM.
- rx_valid is ignored in IDLE, DONE and ERR.
- start_pg=0 while in CMD..CSUM goes to ERR on the next cycle.
- Timeout (CMD..CSUM only):
  - the counter clears on entering CMD and on every rx_valid, and increments otherwise
  - reaching TIMEOUT_CYCLES-1 with no rx_valid moves to ERR, i.e. ERR is entered TIMEOUT_CYCLES cycles after the last byte
- upg_adr_o and upg_dat_o hold their last values when upg_wen_o=0.
- Back-to-back rx_valid on consecutive cycles must be accepted with no byte lost, including a 4th byte immediately followed by the next word's 1st byte.

Test Plan:
- imem, 2 words: bytes 00 02 00 78 56 34 12 EF BE AD DE 28 -> wen pulses {adr=0x0000, dat=0x12345678} then {adr=0x0001, dat=0xDEADBEEF}; then done=1, err=0, cpu_hold=1; cpu_hold=0 after start_pg drops.
- dmem, 1 word: bytes 01 01 00 DD CC BB AA 00 sent on consecutive cycles -> one wen with adr=0x4000, dat=0xAABBCCDD; done=1.
- Same frame as the 1st scenario with CSUM=0x29 -> both wen pulses still occur; err=1, done=0.
- Bad command 0x05 -> ERR next cycle, no wen.
- Length bytes 01 40 (N=0x4001) -> ERR, no wen.
- Length 0 with CSUM=0x00 -> DONE, no wen.
- TIMEOUT_CYCLES=100: send 00 01 00 AA BB then stop -> err=1 exactly 100 cycles after the BB strobe; no wen.
- Reset asserted during DATA -> next cycle state=IDLE, all outputs 0.
- start_pg dropped during DATA -> err=1, then IDLE.
